// File: rtl/obstacle_sched_pkg.sv
// Shared widths, FSM state encoding and slot record for the obstacle line scheduler.
package obstacle_sched_pkg;

  localparam int unsigned OBSTACLE_NUM    = 7;
  localparam int unsigned OBSTACLE_WIDTH  = 10;
  localparam int unsigned BLOCK_LEN_WIDTH = 4;
  localparam int unsigned SCREEN_WIDTH    = 10;
  localparam int unsigned PHY_WIDTH       = 15;
  localparam int unsigned SLOT_NUM        = 4;
  localparam int unsigned ID_W            = $clog2(OBSTACLE_NUM + 1);
  localparam int unsigned SLOT_CNT_W      = $clog2(SLOT_NUM + 1);
  localparam int unsigned SLOT_IDX_W      = $clog2(SLOT_NUM);
  localparam int unsigned MATCH_W         = SCREEN_WIDTH + BLOCK_LEN_WIDTH + 4;
  localparam int unsigned OBSTACLE_HEIGHT = 2 * OBSTACLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [SCREEN_WIDTH-1:0]    screen_x;
    logic [BLOCK_LEN_WIDTH-1:0] len;
    logic [ID_W-1:0]            id;
    logic [PHY_WIDTH-1:0]       abs_x;
    logic [PHY_WIDTH-1:0]       abs_y;
    logic [SCREEN_WIDTH-1:0]    row;
  } slot_t;

endpackage

// File: rtl/obstacle_line_scheduler_if.sv
// Obstacle table read port: address/strobe out, entry data back one cycle later.
interface obstacle_line_scheduler_if;
  import obstacle_sched_pkg::*;

  logic [ID_W-1:0]            obs_rd_idx;
  logic                       obs_rd_en;
  logic [PHY_WIDTH-1:0]       obs_x;
  logic [PHY_WIDTH-1:0]       obs_y;
  logic [SCREEN_WIDTH-1:0]    obs_screen_x;
  logic [BLOCK_LEN_WIDTH-1:0] obs_len;

  modport master (output obs_rd_idx, obs_rd_en, input obs_x, obs_y, obs_screen_x, obs_len);
  modport slave  (input obs_rd_idx, obs_rd_en, output obs_x, obs_y, obs_screen_x, obs_len);
endinterface

// File: rtl/obstacle_slot_buffer.sv
// Double-buffered per-line slot lists: back buffer is filled in order, front buffer
// serves the registered lowest-slot-wins pixel lookup.
module obstacle_slot_buffer
  import obstacle_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    swap,
  input  logic                    wr_en,
  input  slot_t                   wr_slot,
  output logic                    full_c,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  output logic                    hit,
  output logic [ID_W-1:0]         hit_id,
  output logic [SCREEN_WIDTH-1:0] x_rom,
  output logic [SCREEN_WIDTH-1:0] y_rom,
  output logic [PHY_WIDTH-1:0]    abs_x,
  output logic [PHY_WIDTH-1:0]    abs_y
);

  slot_t                 slots [2][SLOT_NUM];
  logic [SLOT_NUM-1:0]   valid [2];
  logic                  front;
  logic                  back;
  logic [SLOT_CNT_W-1:0] back_cnt;
  logic                  do_wr;
  logic                  match_c;
  slot_t                 match_slot_c;
  logic [MATCH_W-1:0]    lo_c;
  logic [MATCH_W-1:0]    hi_c;
  logic [MATCH_W-1:0]    px_c;

  assign back   = ~front;
  assign full_c = (back_cnt == SLOT_CNT_W'(SLOT_NUM));
  assign do_wr  = wr_en & ~swap & ~full_c;

  // Swap retires the old front as the new, cleared back buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front    <= 1'b0;
      back_cnt <= '0;
      valid[0] <= '0;
      valid[1] <= '0;
    end else if (swap) begin
      front        <= back;
      back_cnt     <= '0;
      valid[front] <= '0;
    end else if (do_wr) begin
      valid[back][SLOT_IDX_W'(back_cnt)] <= 1'b1;
      back_cnt <= back_cnt + SLOT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) slots[back][SLOT_IDX_W'(back_cnt)] <= wr_slot;
  end

  always_comb begin
    match_c      = 1'b0;
    match_slot_c = '0;
    lo_c         = '0;
    hi_c         = '0;
    px_c         = MATCH_W'(pixel_x);
    for (int s = 0; s < int'(SLOT_NUM); s++) begin
      lo_c = MATCH_W'(slots[front][s].screen_x);
      hi_c = lo_c + MATCH_W'(slots[front][s].len) * MATCH_W'(OBSTACLE_WIDTH);
      if (!match_c && valid[front][s] && px_c >= lo_c && px_c < hi_c) begin
        match_c      = 1'b1;
        match_slot_c = slots[front][s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit    <= 1'b0;
      hit_id <= '0;
      x_rom  <= '0;
      y_rom  <= '0;
      abs_x  <= '0;
      abs_y  <= '0;
    end else begin
      hit    <= match_c;
      hit_id <= match_slot_c.id;
      x_rom  <= match_c ? (pixel_x - match_slot_c.screen_x) : '0;
      y_rom  <= match_slot_c.row;
      abs_x  <= match_slot_c.abs_x;
      abs_y  <= match_slot_c.abs_y;
    end
  end

endmodule

// File: rtl/obstacle_line_scheduler.sv
// Scans the obstacle table once per scanline, collects rows hitting the next line
// into the back slot buffer and swaps it to the front at the following line start.
module obstacle_line_scheduler
  import obstacle_sched_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    line_start,
  input  logic [SCREEN_WIDTH-1:0] next_line_y,
  input  logic [PHY_WIDTH-1:0]    cam_y,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  obstacle_line_scheduler_if.master obs,
  output logic                    obstacle_on,
  output logic [ID_W-1:0]         obstacle_on_id,
  output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  output logic                    slot_overflow,
  output logic                    scan_late
);

  localparam int unsigned PHY_EXT_W = PHY_WIDTH + 1;

  sched_state_e         state;
  sched_state_e         state_d;
  logic                 rd_en_d;
  logic [ID_W-1:0]      rd_idx_d;
  logic                 late_d;
  logic                 ovf_d;
  logic [PHY_WIDTH-1:0] abs_line;
  logic                 eval_pending;
  logic [ID_W-1:0]      eval_id;
  logic                 hit_c;
  logic                 full_c;
  slot_t                wr_slot_c;
  logic [PHY_EXT_W-1:0] line_ext_c;
  logic [PHY_EXT_W-1:0] bot_ext_c;

  // Hit test on the entry returned for the previous cycle's read; a line start
  // discards any in-flight entry so the swapped buffer stays as-is.
  always_comb begin
    line_ext_c = PHY_EXT_W'(abs_line);
    bot_ext_c  = PHY_EXT_W'(obs.obs_y) + PHY_EXT_W'(OBSTACLE_HEIGHT);
    hit_c      = eval_pending && !line_start && (obs.obs_len != '0) &&
                 (line_ext_c >= PHY_EXT_W'(obs.obs_y)) && (line_ext_c < bot_ext_c);
    wr_slot_c.screen_x = obs.obs_screen_x;
    wr_slot_c.len      = obs.obs_len;
    wr_slot_c.id       = eval_id + ID_W'(1);
    wr_slot_c.abs_x    = obs.obs_x;
    wr_slot_c.abs_y    = obs.obs_y;
    wr_slot_c.row      = SCREEN_WIDTH'(abs_line - obs.obs_y);
  end

  always_comb begin
    state_d  = state;
    rd_en_d  = 1'b0;
    rd_idx_d = '0;
    late_d   = scan_late;
    ovf_d    = slot_overflow | (hit_c & full_c);
    case (state)
      SCAN: begin
        if (obs.obs_rd_idx == ID_W'(OBSTACLE_NUM - 1)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          rd_idx_d = obs.obs_rd_idx + ID_W'(1);
        end
      end
      DRAIN:   state_d = READY;
      default: ;
    endcase
    if (line_start) begin
      state_d  = SCAN;
      rd_en_d  = 1'b1;
      rd_idx_d = '0;
      late_d   = scan_late | (state == SCAN) | (state == DRAIN);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      obs.obs_rd_en  <= 1'b0;
      obs.obs_rd_idx <= '0;
      abs_line       <= '0;
      eval_pending   <= 1'b0;
      eval_id        <= '0;
      scan_late      <= 1'b0;
      slot_overflow  <= 1'b0;
    end else begin
      state          <= state_d;
      obs.obs_rd_en  <= rd_en_d;
      obs.obs_rd_idx <= rd_idx_d;
      eval_pending   <= obs.obs_rd_en & ~line_start;
      eval_id        <= obs.obs_rd_idx;
      scan_late      <= late_d;
      slot_overflow  <= ovf_d;
      if (line_start) abs_line <= cam_y + PHY_WIDTH'(next_line_y);
    end
  end

  obstacle_slot_buffer u_slot_buffer (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .swap    (line_start),
    .wr_en   (hit_c),
    .wr_slot (wr_slot_c),
    .full_c  (full_c),
    .pixel_x (pixel_x),
    .hit     (obstacle_on),
    .hit_id  (obstacle_on_id),
    .x_rom   (obstacle_x_rom),
    .y_rom   (obstacle_y_rom),
    .abs_x   (obstacle_abs_pos_x),
    .abs_y   (obstacle_abs_pos_y)
  );

endmodule

// File: tb/tb_obstacle_line_scheduler.sv
// Directed bench for obstacle_line_scheduler with a 1-cycle-latency table model.
module tb_obstacle_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_line_y = '0;
  logic [14:0] cam_y = '0;
  logic [9:0]  pixel_x = '0;
  logic        on;
  logic [2:0]  id;
  logic [9:0]  xr, yr;
  logic [14:0] ax, ay;
  logic        ovf, late;

  logic [14:0] tx [0:7];
  logic [14:0] ty [0:7];
  logic [9:0]  tsx [0:7];
  logic [3:0]  tlen [0:7];

  int total = 0;
  int bad = 0;

  obstacle_line_scheduler_if bus ();

  obstacle_line_scheduler dut (
    .sys_clk            (clk),
    .sys_rst_n          (rst_n),
    .line_start         (line_start),
    .next_line_y        (next_line_y),
    .cam_y              (cam_y),
    .pixel_x            (pixel_x),
    .obs                (bus),
    .obstacle_on        (on),
    .obstacle_on_id     (id),
    .obstacle_x_rom     (xr),
    .obstacle_y_rom     (yr),
    .obstacle_abs_pos_x (ax),
    .obstacle_abs_pos_y (ay),
    .slot_overflow      (ovf),
    .scan_late          (late)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.obs_rd_en) begin
      bus.obs_x        <= tx[bus.obs_rd_idx];
      bus.obs_y        <= ty[bus.obs_rd_idx];
      bus.obs_screen_x <= tsx[bus.obs_rd_idx];
      bus.obs_len      <= tlen[bus.obs_rd_idx];
    end
  end

  task automatic clear_table();
    for (int i = 0; i < 8; i++) begin
      tx[i] = '0; ty[i] = '0; tsx[i] = '0; tlen[i] = '0;
    end
  endtask

  task automatic set_entry(input int i, input int x, input int y, input int sx, input int len);
    tx[i] = 15'(x); ty[i] = 15'(y); tsx[i] = 10'(sx); tlen[i] = 4'(len);
  endtask

  task automatic pulse(input int c, input int n);
    @(negedge clk);
    line_start = 1'b1; cam_y = 15'(c); next_line_y = 10'(n);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic run_line(input int c, input int n);
    pulse(c, n);
    repeat (8) @(negedge clk);
  endtask

  task automatic probe(input int p);
    @(negedge clk);
    pixel_x = 10'(p);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (on !== 1'b0 || id !== 3'd0) begin bad++; $display("FAIL reset_pixel on=%0b id=%0d want 0 0", on, id); end
    total++; if (bus.obs_rd_en !== 1'b0 || bus.obs_rd_idx !== 3'd0) begin bad++; $display("FAIL reset_rd en=%0b idx=%0d want 0 0", bus.obs_rd_en, bus.obs_rd_idx); end
    total++; if (ovf !== 1'b0 || late !== 1'b0) begin bad++; $display("FAIL reset_flags ovf=%0b late=%0b want 0 0", ovf, late); end
    rst_n = 1'b1;
    clear_table();
    set_entry(2, 1234, 100, 40, 3);
    pulse(90, 15);
    repeat (3) @(negedge clk);
    total++; if (bus.obs_rd_idx !== 3'd3 || bus.obs_rd_en !== 1'b1) begin bad++; $display("FAIL scan_idx3 idx=%0d en=%0b want 3 1", bus.obs_rd_idx, bus.obs_rd_en); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.obs_rd_en !== 1'b0 || bus.obs_rd_idx !== 3'd0) begin bad++; $display("FAIL async_reset_rd en=%0b idx=%0d want 0 0", bus.obs_rd_en, bus.obs_rd_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    run_line(90, 15);
    probe(40);
    total++; if (on !== 1'b0) begin bad++; $display("FAIL front_empty_after_reset on=%0b want 0", on); end
  endtask

  task automatic test_basic();
    int px [5] = '{40, 55, 69, 70, 39};
    logic exp_on [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int exp_xr [5] = '{0, 15, 29, 0, 0};
    clear_table();
    set_entry(2, 1234, 100, 40, 3);
    run_line(90, 15);
    total++; if (bus.obs_rd_en !== 1'b0) begin bad++; $display("FAIL scan_done rd_en=%0b want 0", bus.obs_rd_en); end
    run_line(0, 0);
    for (int k = 0; k < 5; k++) begin
      probe(px[k]);
      total++;
      if (exp_on[k]) begin
        if ({on, id, xr, yr, ax, ay} !== {1'b1, 3'd3, 10'(exp_xr[k]), 10'd5, 15'd1234, 15'd100}) begin
          bad++; $display("FAIL basic_hit px=%0d got on=%0b id=%0d xr=%0d yr=%0d ax=%0d ay=%0d want 1 3 %0d 5 1234 100", px[k], on, id, xr, yr, ax, ay, exp_xr[k]);
        end
      end else if ({on, id, xr, yr, ax, ay} !== '0) begin
        bad++; $display("FAIL basic_miss px=%0d got on=%0b id=%0d xr=%0d yr=%0d want all 0", px[k], on, id, xr, yr);
      end
    end
    total++; if (ovf !== 1'b0 || late !== 1'b0) begin bad++; $display("FAIL basic_flags ovf=%0b late=%0b want 0 0", ovf, late); end
  endtask

  task automatic test_bounds();
    clear_table();
    set_entry(2, 1234, 100, 40, 3);
    run_line(100, 20);
    run_line(0, 0);
    probe(40);
    total++; if (on !== 1'b0 || id !== 3'd0) begin bad++; $display("FAIL bound_120 on=%0b id=%0d want 0 0", on, id); end
    run_line(100, 19);
    run_line(0, 0);
    probe(69);
    total++; if (on !== 1'b1 || id !== 3'd3 || yr !== 10'd19 || xr !== 10'd29) begin bad++; $display("FAIL bound_119 on=%0b id=%0d yr=%0d xr=%0d want 1 3 19 29", on, id, yr, xr); end
  endtask

  task automatic test_overflow();
    clear_table();
    set_entry(0, 1000, 200, 100, 2);
    set_entry(1, 1001, 200, 110, 2);
    set_entry(2, 1002, 200, 300, 1);
    set_entry(3, 1003, 200, 400, 1);
    set_entry(4, 1004, 200, 500, 1);
    run_line(200, 5);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL overflow_flag ovf=%0b want 1", ovf); end
    run_line(0, 0);
    probe(115);
    total++; if (on !== 1'b1 || id !== 3'd1 || xr !== 10'd15 || yr !== 10'd5 || ax !== 15'd1000) begin bad++; $display("FAIL overlap_prio on=%0b id=%0d xr=%0d yr=%0d ax=%0d want 1 1 15 5 1000", on, id, xr, yr, ax); end
    probe(125);
    total++; if (on !== 1'b1 || id !== 3'd2 || xr !== 10'd15) begin bad++; $display("FAIL second_slot on=%0b id=%0d xr=%0d want 1 2 15", on, id, xr); end
    probe(405);
    total++; if (on !== 1'b1 || id !== 3'd4 || xr !== 10'd5 || ax !== 15'd1003) begin bad++; $display("FAIL last_slot on=%0b id=%0d xr=%0d ax=%0d want 1 4 5 1003", on, id, xr, ax); end
    probe(505);
    total++; if (on !== 1'b0 || id !== 3'd0) begin bad++; $display("FAIL dropped_entry on=%0b id=%0d want 0 0", on, id); end
  endtask

  task automatic test_late();
    clear_table();
    set_entry(0, 10, 300, 20, 1);
    set_entry(5, 60, 300, 600, 1);
    pulse(300, 5);
    repeat (3) @(negedge clk);
    pulse(300, 5);
    total++; if (late !== 1'b1) begin bad++; $display("FAIL scan_late late=%0b want 1", late); end
    total++; if (bus.obs_rd_idx !== 3'd0 || bus.obs_rd_en !== 1'b1) begin bad++; $display("FAIL restart_idx idx=%0d en=%0b want 0 1", bus.obs_rd_idx, bus.obs_rd_en); end
    probe(20);
    total++; if (on !== 1'b1 || id !== 3'd1) begin bad++; $display("FAIL partial_hit on=%0b id=%0d want 1 1", on, id); end
    probe(600);
    total++; if (on !== 1'b0) begin bad++; $display("FAIL partial_unscanned on=%0b want 0", on); end
    repeat (9) @(negedge clk);
    run_line(0, 0);
    probe(600);
    total++; if (on !== 1'b1 || id !== 3'd6 || ax !== 15'd60) begin bad++; $display("FAIL rescan_full on=%0b id=%0d ax=%0d want 1 6 60", on, id, ax); end
  endtask

  task automatic test_len0();
    clear_table();
    set_entry(1, 7, 400, 50, 0);
    set_entry(3, 9, 400, 80, 1);
    run_line(400, 3);
    run_line(0, 0);
    probe(50);
    total++; if (on !== 1'b0 || id !== 3'd0) begin bad++; $display("FAIL len0_entry on=%0b id=%0d want 0 0", on, id); end
    probe(85);
    total++; if (on !== 1'b1 || id !== 3'd4 || yr !== 10'd3) begin bad++; $display("FAIL len0_neighbor on=%0b id=%0d yr=%0d want 1 4 3", on, id, yr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_overflow();
    test_late();
    test_len0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/obstacle_line_scheduler.md
# obstacle_line_scheduler

Builds a per-scanline list of visible obstacles and drives the obstacle pixel inputs of `obstacle_display_controller` (`obstacle_on`, `obstacle_on_id`, ROM coordinates, absolute positions). During each line it scans the obstacle table through a 1-cycle-latency read port and fills a back slot buffer for the next line. It then swaps buffers at the next line start, so pixel lookup runs from a stable front buffer. It sits between the obstacle table / camera logic and the display controller in the VGA path.

## Interface
- `OBSTACLE_NUM`, 7, number of table entries (indices 0..N-1)
- `OBSTACLE_WIDTH`, 10, block width in pixels; obstacle height is 2×`OBSTACLE_WIDTH`
- `BLOCK_LEN_WIDTH`, 4, width of obstacle length field (blocks)
- `SCREEN_WIDTH`, 10, pixel coordinate width
- `PHY_WIDTH`, 15, absolute world coordinate width
- `SLOT_NUM`, 4, max obstacles per line
- `ID_W`, localparam, `$clog2(OBSTACLE_NUM+1)`
- `sys_clk` in 1: pixel clock, single clock domain
- `sys_rst_n` in 1: asynchronous, active-low reset
- `line_start` in 1: one-cycle pulse at start of horizontal blanking
- `next_line_y` in `SCREEN_WIDTH`: screen row to prepare; sampled on `line_start`
- `cam_y` in `PHY_WIDTH`: world y of screen row 0; sampled on `line_start`
- `pixel_x` in `SCREEN_WIDTH`: current pixel column
- `obs_rd_idx` out `ID_W`: table read address
- `obs_rd_en` out 1: read strobe; data is valid the next cycle
- `obs_x`, `obs_y` in `PHY_WIDTH`: entry absolute position
- `obs_screen_x` in `SCREEN_WIDTH`: entry left column on screen
- `obs_len` in `BLOCK_LEN_WIDTH`: entry length in blocks; 0 means empty entry
- `obstacle_on` out 1: current pixel covered
- `obstacle_on_id` out `ID_W`: table index + 1; 0 when not covered
- `obstacle_x_rom`, `obstacle_y_rom` out `SCREEN_WIDTH`: offset inside obstacle
- `obstacle_abs_pos_x`, `obstacle_abs_pos_y` out `PHY_WIDTH`: `obs_x`, `obs_y` of the hit entry
- `slot_overflow`, `scan_late` out 1: sticky error flags, cleared only by reset

## Operation
- FSM states: `IDLE`, `SCAN`, `DRAIN`, `READY`.
- `line_start` in any state:
  - swap front/back buffers;
  - clear the new back buffer;
  - latch `abs_line = cam_y + next_line_y`, zero-extended and computed modulo 2^`PHY_WIDTH`;
  - go to `SCAN` with index 0.
- `SCAN`:
  - assert `obs_rd_en` with `obs_rd_idx` = 0..N-1 on consecutive cycles;
  - after index N-1, go to `DRAIN` for one cycle to evaluate the last returned entry.
- Per returned entry:
  - hit if `obs_len` ≠ 0 and `obs_y` ≤ `abs_line` < `obs_y` + 2×`OBSTACLE_WIDTH`, with no wrap;
  - a hit stores {`screen_x`, `len`, `id`, `obs_x`, `obs_y`, `row` = `abs_line` − `obs_y`} in the next free back slot, in ascending index order;
  - a hit with all `SLOT_NUM` slots full is dropped and sets `slot_overflow`.
- `DRAIN` → `READY`. `READY` holds until the next `line_start`.
- `line_start` while in `SCAN` or `DRAIN`:
  - set `scan_late`;
  - the partial back buffer is swapped in as-is;
  - the new scan restarts at index 0.
- Pixel lookup on the front buffer:
  - slot s matches if `screen_x` ≤ `pixel_x` < `screen_x` + `len`×`OBSTACLE_WIDTH`, computed at `SCREEN_WIDTH`+`BLOCK_LEN_WIDTH`+4 bits with no wrap;
  - lowest s wins;
  - `obstacle_x_rom` = `pixel_x` − `screen_x`;
  - `obstacle_y_rom` = `row`.
- On a miss, all obstacle outputs are 0.

## Timing
- Reset values:
  - FSM `IDLE`, both buffers empty;
  - all outputs 0, including `obs_rd_en`, `obs_rd_idx`, and both flags.
- Pixel outputs are registered, with 1-cycle latency from `pixel_x`.
- A full scan takes `OBSTACLE_NUM` + 2 cycles after `line_start`. The minimum legal `line_start` spacing is therefore `OBSTACLE_NUM` + 2.
- Reset asserted mid-scan returns everything to reset values immediately, asynchronously.
- Until the first swap after reset, the front buffer is empty and `obstacle_on` = 0.

## Structure
- Package `obstacle_sched_pkg` holds:
  - the FSM state enum;
  - the slot record typedef {screen_x, len, id, abs_x, abs_y, row};
  - the obstacle height constant 2×`OBSTACLE_WIDTH`.
- Sub-module `obstacle_slot_buffer` holds the double-buffered slot arrays, swap, write port and priority match. The top level holds the FSM, read sequencing and hit test.

## Test plan
- Reset mid-`SCAN` (at index 3) → all outputs 0 immediately; after reset release, `obstacle_on` = 0 until a scan plus swap completes.
- Entry 2: `obs_y`=100, `screen_x`=40, `len`=3; `cam_y`=90, `next_line_y`=15, `line_start` → after 9 cycles and the next `line_start`, `pixel_x`=40..69 gives `obstacle_on`=1, `id`=3, `y_rom`=5, `x_rom`=0..29; `pixel_x`=70 gives off.
- Same entry with `abs_line`=120 (exclusive bound) → no hit; with `abs_line`=119 → `y_rom`=19.
- Five overlapping hits with `SLOT_NUM`=4 → entries 0-3 stored, entry 4 dropped, `slot_overflow`=1; the overlapping pixel reports `id`=1.
- `line_start` pulses 5 cycles apart → `scan_late`=1, partial buffer displayed, next scan restarts at `obs_rd_idx`=0.
- `obs_len`=0 entry whose rows cover `abs_line` → never hits; `obstacle_on_id`=0.
